// File: rtl/uno_pkg.sv
// uno_pkg: shared definitions for the uno command sequencer.
//   - op encoding and sequencer state enums
//   - default widths / term count
//   - per-op polynomial coefficient tables, indexed by power of X
//     (entry 0 is the constant term, entry DEF_TERMS-1 the highest power)
package uno_pkg;

  localparam int DEF_MAC_BW = 12;
  localparam int DEF_TERMS  = 4;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    OP_MAC = 2'b00,
    OP_DIV = 2'b01,
    OP_EXP = 2'b10,
    OP_LOG = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MAC_RUN  = 3'd1,
    ST_POLY_RUN = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  typedef logic [DEF_MAC_BW-1:0] coeff_t;

  localparam coeff_t DIV_COEFF [DEF_TERMS] = '{12'h400, 12'h2C3, 12'h1A5, 12'h0F0};
  localparam coeff_t EXP_COEFF [DEF_TERMS] = '{12'h001, 12'h008, 12'h040, 12'h100};
  localparam coeff_t LOG_COEFF [DEF_TERMS] = '{12'h0AA, 12'h155, 12'h2AA, 12'h3FF};

endpackage

// File: rtl/uno_coeff_rom.sv
// uno_coeff_rom: combinational coefficient lookup.
// Ports:
//   op    in  2      op select (OP_MAC returns 0)
//   idx   in  IDX_W  power-of-X index; indices >= TERMS return 0
//   coeff out MAC_BW coefficient
module uno_coeff_rom
  import uno_pkg::*;
#(
  parameter int MAC_BW = DEF_MAC_BW,
  parameter int TERMS  = DEF_TERMS,
  parameter int IDX_W  = $clog2(TERMS)
) (
  input  logic [1:0]        op,
  input  logic [IDX_W-1:0]  idx,
  output logic [MAC_BW-1:0] coeff
);

  always_comb begin
    coeff = '0;
    // Entries beyond the package table (or beyond TERMS) read as zero.
    for (int i = 0; i < DEF_TERMS; i++) begin
      if (i < TERMS && idx == IDX_W'(i)) begin
        case (op)
          OP_DIV:  coeff = MAC_BW'(DIV_COEFF[i]);
          OP_EXP:  coeff = MAC_BW'(EXP_COEFF[i]);
          OP_LOG:  coeff = MAC_BW'(LOG_COEFF[i]);
          default: coeff = '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/uno_seq.sv
// uno_seq: command sequencer in front of the unified MAC/div/exp/log PE.
// Accepts one command, streams MAC elements or walks the coefficient ROM
// in Horner order, then returns the PE's registered result.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/ready, cmd_op, cmd_x, cmd_y, cmd_z, cmd_len   command port
//   el_valid/ready, el_x, el_y                            MAC element port
//   pe_op, pe_x, pe_y, pe_z, pe_coeff                     PE operands
//   pe_first_cycle, pe_last_cycle, pe_acc_en              PE strobes
//   pe_res                                                PE result (1-cycle latency)
//   res_valid/ready, res_data                             response port
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Producers hold valid and payload until the transfer; ready here
// is a pure function of state and never depends on the matching valid.
module uno_seq
  import uno_pkg::*;
#(
  parameter int MAC_BW = DEF_MAC_BW,
  parameter int TERMS  = DEF_TERMS,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [MAC_BW-1:0]     cmd_x,
  input  logic [MAC_BW-1:0]     cmd_y,
  input  logic [2*MAC_BW-1:0]   cmd_z,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  el_valid,
  output logic                  el_ready,
  input  logic [MAC_BW-1:0]     el_x,
  input  logic [MAC_BW-1:0]     el_y,
  output logic [1:0]            pe_op,
  output logic [MAC_BW-1:0]     pe_x,
  output logic [MAC_BW-1:0]     pe_y,
  output logic [2*MAC_BW-1:0]   pe_z,
  output logic [MAC_BW-1:0]     pe_coeff,
  output logic                  pe_first_cycle,
  output logic                  pe_last_cycle,
  output logic                  pe_acc_en,
  input  logic [2*MAC_BW-1:0]   pe_res,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*MAC_BW-1:0]   res_data
);

  localparam int IDX_W = $clog2(TERMS);
  localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(TERMS - 1);

  state_e                state_q, state_d;
  logic [1:0]            op_q;
  logic [MAC_BW-1:0]     x_q, y_q;
  logic [2*MAC_BW-1:0]   z_q, res_q;
  logic [LEN_W-1:0]      len_q, count_q;
  logic [IDX_W-1:0]      step_q, rom_idx;
  logic [MAC_BW-1:0]     rom_coeff;
  logic                  cmd_fire, el_fire, res_fire;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign el_fire  = el_valid && el_ready;
  assign res_fire = res_valid && res_ready;

  // Horner order: highest power first.
  assign rom_idx = LAST_STEP - step_q;

  uno_coeff_rom #(
    .MAC_BW (MAC_BW),
    .TERMS  (TERMS),
    .IDX_W  (IDX_W)
  ) u_rom (
    .op    (op_q),
    .idx   (rom_idx),
    .coeff (rom_coeff)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_op != OP_MAC)     state_d = ST_POLY_RUN;
          else if (cmd_len == '0)   state_d = ST_RESP;
          else                      state_d = ST_MAC_RUN;
        end
      end
      ST_MAC_RUN:  if (el_fire && count_q == len_q - LEN_W'(1)) state_d = ST_DRAIN;
      ST_POLY_RUN: if (step_q == LAST_STEP) state_d = ST_DRAIN;
      ST_DRAIN:    state_d = ST_RESP;
      ST_RESP:     if (res_fire) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Command latch, counters and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      len_q   <= '0;
      count_q <= '0;
      step_q  <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            op_q    <= cmd_op;
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            z_q     <= cmd_z;
            len_q   <= cmd_len;
            count_q <= '0;
            step_q  <= '0;
            // Empty MAC vector: the answer is the initial accumulator.
            if (cmd_op == OP_MAC && cmd_len == '0) res_q <= cmd_z;
          end
        end
        ST_MAC_RUN: if (el_fire) count_q <= count_q + LEN_W'(1);
        ST_POLY_RUN: step_q <= (step_q == LAST_STEP) ? '0 : step_q + IDX_W'(1);
        // The last step's result is on pe_res during the drain cycle.
        ST_DRAIN: res_q <= pe_res;
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    cmd_ready      = 1'b0;
    el_ready       = 1'b0;
    res_valid      = 1'b0;
    pe_op          = '0;
    pe_x           = '0;
    pe_y           = '0;
    pe_z           = '0;
    pe_coeff       = '0;
    pe_first_cycle = 1'b0;
    pe_last_cycle  = 1'b0;
    pe_acc_en      = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready = 1'b1;
      ST_MAC_RUN: begin
        el_ready = 1'b1;
        pe_op    = OP_MAC;
        pe_z     = z_q;
        // The PE runs every cycle: once an element has gone in, keep
        // accumulating so bubbles (zero operands) add nothing.
        pe_acc_en = (count_q != '0);
        if (el_valid) begin
          pe_x = el_x;
          pe_y = el_y;
        end
      end
      ST_POLY_RUN: begin
        pe_op          = op_q;
        pe_x           = x_q;
        pe_y           = y_q;
        pe_coeff       = rom_coeff;
        pe_first_cycle = (step_q == '0);
        pe_last_cycle  = (step_q == LAST_STEP);
      end
      ST_RESP: res_valid = 1'b1;
      default: ;
    endcase
  end

  assign res_data = res_q;

endmodule

// File: doc/uno_seq.md
Name: uno_seq

Overview:
Command sequencer that sits directly upstream of the unified MAC/div/exp/log PE and drives its control and operand inputs. It accepts one operation per command over a valid/ready handshake. For MAC it streams vector elements; for div/exp/log it walks a per-op coefficient ROM in Horner order and pulses first/last-cycle strobes. It captures the PE's registered result and returns it over a valid/ready response port.

Parameters:
MAC_BW, 12, operand width (matches PE)
TERMS, 4, polynomial coefficients per nonlinear op (>=2)
LEN_W, 8, width of MAC vector length field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept
cmd_op  in  2  00 MAC, 01 div, 10 exp, 11 log
cmd_x  in  MAC_BW  nonlinear operand X
cmd_y  in  MAC_BW  nonlinear operand Y (div dividend)
cmd_z  in  2*MAC_BW  MAC initial accumulator
cmd_len  in  LEN_W  MAC element count (ignored for nonlinear ops)
el_valid  in  1  MAC element valid
el_ready  out  1  MAC element accept
el_x, el_y  in  MAC_BW each  MAC element operands
pe_op  out  2  PE op select
pe_x, pe_y  out  MAC_BW each  PE X/Y
pe_z  out  2*MAC_BW  PE Z
pe_coeff  out  MAC_BW  PE coefficient
pe_first_cycle, pe_last_cycle, pe_acc_en  out  1 each  PE strobes
pe_res  in  2*MAC_BW  PE registered result (1-cycle latency)
res_valid  out  1  result valid
res_ready  in  1  result accept
res_data  out  2*MAC_BW  result

Behaviour:
- PE contract: fixed 1-cycle latency. Operands presented in cycle n appear on pe_res in cycle n+1.
- Reset (async assert): state IDLE; every registered output is 0; res_data 0; step and element counters 0. Reset mid-operation abandons the op. No res_valid is produced for it, and cmd_ready=1 on the first cycle after deassert.
- States: IDLE, MAC_RUN, POLY_RUN, DRAIN, RESP.
- IDLE: cmd_ready=1; el_ready=0; PE outputs zero with strobes 0.
  - On cmd_valid&cmd_ready, latch op/x/y/z/len.
  - op=00, len=0: go to RESP with res_data=cmd_z.
  - op=00, len>0: go to MAC_RUN.
  - Otherwise: go to POLY_RUN with step=0.
- MAC_RUN:
  - el_ready=1; pe_op=00; pe_z=latched z.
  - On element handshake: pe_x=el_x, pe_y=el_y; pe_acc_en=0 for the first element, 1 for later ones; count++.
  - Bubble (el_valid=0): pe_x=pe_y=0 and pe_acc_en=1 once at least one element has been issued, so the free-running PE adds 0.
  - After the count reaches len on a handshake, go to DRAIN.
- POLY_RUN: one step per cycle, no stalls, steps k=0..TERMS-1.
  - pe_op=latched op; pe_x=latched x; pe_y=latched y.
  - pe_coeff=ROM[op][TERMS-1-k].
  - pe_first_cycle=1 only at k=0; pe_last_cycle=1 only at k=TERMS-1.
  - After the last step, go to DRAIN.
- DRAIN: one cycle, PE outputs zero and strobes 0. Capture res_data<=pe_res, then go to RESP.
- RESP: res_valid=1. res_data holds stable until res_ready. On the handshake go to IDLE.
- cmd_ready=0 and el_ready=0 outside IDLE and MAC_RUN respectively.
- res_ready together with a pending cmd_valid in RESP: the command is not accepted until the following IDLE cycle.
- Latency for a nonlinear op: accept at edge t, steps in cycles t+1..t+TERMS, DRAIN at t+TERMS+1, res_valid at t+TERMS+2.
- No arithmetic inside the block. The result width is passed through from the PE unchanged.

Decomposition:
- uno_pkg holds:
  - op encoding enum (OP_MAC, OP_DIV, OP_EXP, OP_LOG)
  - state enum
  - MAC_BW default
  - per-op coefficient constant arrays [TERMS] for div/exp/log
- One sub-module, uno_coeff_rom: combinational (op, idx) -> coeff. It returns 0 for OP_MAC or an out-of-range idx.

Test Plan:
- MAC, z=10, len=3, elements (1,2),(3,4),(5,6) back-to-back -> pe_acc_en 0,1,1; res_data=54; res_valid 2 cycles after the last element handshake.
- Same MAC with el_valid low for 2 cycles between elements 1 and 2 -> bubble cycles show pe_x=pe_y=0 and pe_acc_en=1; res_data=54.
- MAC len=0, z=7 -> no el_ready; res_valid the cycle after accept, res_data=7.
- exp command, x=0x180, TERMS=4 -> pe_coeff = ROM[exp][3], [2], [1], [0] in cycles t+1..t+4; first strobe only at t+1, last only at t+4; res_valid at t+6 equals pe_res sampled at t+5.
- res_ready held low 5 cycles in RESP while cmd_valid=1 -> res_data stable, cmd_ready=0; accept occurs the cycle after the res handshake.
- rst_n asserted at step 2 of a log op -> outputs 0 immediately; after release, IDLE with cmd_ready=1 and no res_valid; the next command completes normally.
